// File: rtl/lfsr_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared types and constants for the LFSR random-number stage.
//                FSM state encoding, default width, feedback taps and the
//                substitute seed used when the XOR seed collapses to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  localparam int             c_WIDTH    = 7;
  localparam logic [6:0]     c_TAPS     = 7'h60;  // x^7 + x^6 + 1, period 127
  localparam int             c_WARMUP   = 4;
  localparam logic [6:0]     c_ZERO_SUB = 7'h55;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    DONE = 2'd2
  } lfsr_state_t;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lfsr_core
//  Description : Combinational Fibonacci LFSR step. The feedback bit is the
//                XOR of the tapped bits, shifted in at the LSB.
//  Ports       : i_lfsr      [WIDTH] current register value
//                o_lfsr_next [WIDTH] value after one step
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = c_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = c_TAPS
) (
  input  logic [WIDTH-1:0] i_lfsr,
  output logic [WIDTH-1:0] o_lfsr_next
);

  logic w_fb;

  assign w_fb        = ^(i_lfsr & TAPS);
  assign o_lfsr_next = {i_lfsr[WIDTH-2:0], w_fb};

endmodule : lfsr_core
`default_nettype wire

// File: rtl/lfsr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : On request, seeds an LFSR from a free-running timing
//                counter, runs WARMUP steps, then presents a non-zero value
//                with complete_LFSR held until the request drops.
//  Ports       : clk            system clock (posedge)
//                rst_LFSR       synchronous active-high reset
//                en_LFSR        level request from the consumer
//                LFSR_output    [WIDTH] random value, stable while complete
//                complete_LFSR  registered value-valid flag
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = c_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = c_TAPS,
  parameter int               WARMUP   = c_WARMUP,
  parameter logic [WIDTH-1:0] ZERO_SUB = c_ZERO_SUB
) (
  input  logic             clk,
  input  logic             rst_LFSR,
  input  logic             en_LFSR,
  output logic [WIDTH-1:0] LFSR_output,
  output logic             complete_LFSR
);

  localparam int                  c_WARM_W    = $clog2(WARMUP + 1);
  localparam logic [c_WARM_W-1:0] c_WARM_LAST = c_WARM_W'(WARMUP - 1);

  lfsr_state_t         r_state;
  logic [WIDTH-1:0]    r_lfsr;
  logic [WIDTH-1:0]    r_seed_cnt;
  logic [c_WARM_W-1:0] r_warm_cnt;
  logic [WIDTH-1:0]    w_lfsr_next;
  logic [WIDTH-1:0]    w_seed;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .i_lfsr      (r_lfsr),
    .o_lfsr_next (w_lfsr_next)
  );

  // Mixing in the current LFSR state means back-to-back requests with the
  // same timing still diverge. A zero seed would lock the LFSR, so swap it.
  assign w_seed = r_seed_cnt ^ r_lfsr;

  always_ff @(posedge clk) begin
    if (rst_LFSR) begin
      r_state       <= IDLE;
      r_lfsr        <= WIDTH'(1);
      r_seed_cnt    <= '0;
      r_warm_cnt    <= '0;
      LFSR_output   <= '0;
      complete_LFSR <= 1'b0;
    end else begin
      // Timing entropy: counts in every state, wraps naturally.
      r_seed_cnt <= r_seed_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (en_LFSR) begin
            r_lfsr     <= (w_seed == '0) ? ZERO_SUB : w_seed;
            r_warm_cnt <= '0;
            r_state    <= WARM;
          end
        end
        WARM: begin
          if (!en_LFSR) begin
            // Abort keeps the partially stepped LFSR as future entropy.
            r_state <= IDLE;
          end else begin
            r_lfsr     <= w_lfsr_next;
            r_warm_cnt <= r_warm_cnt + 1'b1;
            if (r_warm_cnt == c_WARM_LAST) begin
              r_state       <= DONE;
              LFSR_output   <= w_lfsr_next;
              complete_LFSR <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!en_LFSR) begin
            r_state       <= IDLE;
            complete_LFSR <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : lfsr_gen
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_gen
//  Description : Self-checking bench for lfsr_gen. Directed request vectors
//                with hand-computed results, plus abort, reset, hold, period
//                and random non-zero sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_gen;
  import lfsr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_LFSR;
  logic       en_LFSR;
  logic [6:0] LFSR_output;
  logic       complete_LFSR;

  logic [6:0] m_in;
  logic [6:0] m_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk           (clk),
    .rst_LFSR      (rst_LFSR),
    .en_LFSR       (en_LFSR),
    .LFSR_output   (LFSR_output),
    .complete_LFSR (complete_LFSR)
  );

  lfsr_core #(.WIDTH(7), .TAPS(7'h60)) ref_core (
    .i_lfsr      (m_in),
    .o_lfsr_next (m_out)
  );

  typedef struct {
    int         idle;   // idle edges after reset = seed_cnt at request edge
    logic [6:0] exp;
    bit         hold;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_LFSR = 1'b1;
    en_LFSR  = 1'b0;
    tick();
    rst_LFSR = 1'b0;
  endtask

  // Idle for 'idle' edges, raise the request, expect completion after
  // WARMUP+1 edges with value 'exp', optionally hold, then release.
  task automatic request(input string name, input int idle, input logic [6:0] exp, input bit hold);
    int cnt;
    int unstable;
    repeat (idle) tick();
    en_LFSR = 1'b1;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!complete_LFSR && cnt < 20);
    check({name, " latency"}, cnt, 5);
    check({name, " value"}, LFSR_output, exp);
    if (hold) begin
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (LFSR_output !== exp || complete_LFSR !== 1'b1) unstable++;
      end
      check({name, " hold unstable cycles"}, unstable, 0);
    end
    en_LFSR = 1'b0;
    tick();
    check({name, " complete drop"}, complete_LFSR, 0);
    check({name, " value kept"}, LFSR_output, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] v;
    int first_ret;
    bit saw_zero;
    int cnt;

    vecs[0] = '{idle: 5,   exp: 7'h41, hold: 1'b1};  // seed 0x04
    vecs[1] = '{idle: 1,   exp: 7'h5F, hold: 1'b0};  // zero seed -> 0x55
    vecs[2] = '{idle: 0,   exp: 7'h10, hold: 1'b0};  // seed 0x01
    vecs[3] = '{idle: 3,   exp: 7'h20, hold: 1'b0};  // seed 0x02
    vecs[4] = '{idle: 2,   exp: 7'h30, hold: 1'b0};  // seed 0x03
    vecs[5] = '{idle: 127, exp: 7'h60, hold: 1'b0};  // seed 0x7E
    vecs[6] = '{idle: 128, exp: 7'h10, hold: 1'b0};  // counter wrapped, seed 0x01

    rst_LFSR = 1'b1;
    en_LFSR  = 1'b0;
    m_in     = 7'h01;

    // Period of the step function from 0x01.
    v = 7'h01;
    first_ret = 0;
    saw_zero = 1'b0;
    for (int i = 1; i <= 127; i++) begin
      m_in = v;
      #1;
      v = m_out;
      if (v == 7'h00) saw_zero = 1'b1;
      if (v == 7'h01 && first_ret == 0) first_ret = i;
    end
    check("core period", first_ret, 127);
    check("core zero seen", saw_zero, 0);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      check($sformatf("vec%0d reset value", i), LFSR_output, 0);
      check($sformatf("vec%0d reset complete", i), complete_LFSR, 0);
      request($sformatf("vec%0d", i), vecs[i].idle, vecs[i].exp, vecs[i].hold);
    end

    // Abort two steps into WARM after a completed request.
    do_reset();
    request("pre-abort", 5, 7'h41, 1'b0);      // lfsr ends at 0x41, next seed_cnt 11
    en_LFSR = 1'b1;
    tick();                                    // seed 11 ^ 0x41 = 0x4A
    check("abort warm complete0", complete_LFSR, 0);
    tick();                                    // 0x15
    tick();                                    // 0x2A
    check("abort warm complete2", complete_LFSR, 0);
    en_LFSR = 1'b0;
    tick();                                    // abort edge
    check("abort complete", complete_LFSR, 0);
    check("abort value kept", LFSR_output, 7'h41);
    request("post-abort", 1, 7'h29, 1'b0);     // seed 16 ^ 0x2A = 0x3A

    // Reset in the middle of WARM.
    do_reset();
    en_LFSR = 1'b1;
    tick();
    tick();
    rst_LFSR = 1'b1;
    en_LFSR  = 1'b0;
    tick();
    rst_LFSR = 1'b0;
    check("warm-reset value", LFSR_output, 0);
    check("warm-reset complete", complete_LFSR, 0);
    request("after warm-reset", 5, 7'h41, 1'b0);

    // Reset while DONE.
    do_reset();
    en_LFSR = 1'b1;
    repeat (5) tick();
    check("done-reset pre complete", complete_LFSR, 1);
    rst_LFSR = 1'b1;
    en_LFSR  = 1'b0;
    tick();
    rst_LFSR = 1'b0;
    check("done-reset value", LFSR_output, 0);
    check("done-reset complete", complete_LFSR, 0);
    request("after done-reset", 1, 7'h5F, 1'b0);

    // Random request timing: output must always be non-zero.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 9)) tick();
      en_LFSR = 1'b1;
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (!complete_LFSR && cnt < 20);
      check("rand latency", cnt, 5);
      check("rand nonzero", (LFSR_output != 7'h00), 1);
      en_LFSR = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lfsr_gen
`default_nettype wire
